// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 sequencer: opcode encodings, field widths and FSM states.
package td4_pkg;

    localparam int OP_W    = 4;
    localparam int IMM_W   = 4;
    localparam int PC_W    = 4;
    localparam int INSTR_W = OP_W + IMM_W;

    localparam logic [OP_W-1:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [OP_W-1:0] OP_JNC      = 4'b1110;
    localparam logic [OP_W-1:0] OP_JMP      = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    // Only the immediate-add instructions produce a carry worth keeping.
    function automatic logic is_add_imm(input logic [OP_W-1:0] op);
        return (op == OP_ADD_A_IM) || (op == OP_ADD_B_IM);
    endfunction

endpackage

// File: rtl/td4_branch_eval.sv
// Combinational branch resolution: decides whether the EXEC cycle loads the PC or lets it increment.
module td4_branch_eval
    import td4_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    input  logic [IMM_W-1:0] imm,
    input  logic             carry_flag,
    input  logic [PC_W-1:0]  pc_cur,
    output logic             pc_ld_n,
    output logic [PC_W-1:0]  pc_load
);

    logic taken;

    assign taken = (op == OP_JMP) || ((op == OP_JNC) && !carry_flag);

    always_comb begin
        pc_ld_n = 1'b1;
        pc_load = pc_cur;
        if (taken) begin
            pc_ld_n = 1'b0;
            pc_load = imm;
        end
    end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 instruction sequencer: fetch/decode/exec FSM with PC hold/load control and a local carry flag.
// Optional single-step support is enabled by defining TD4_SEQ_STEP_EN.
module td4_sequencer
    import td4_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step,
    output logic                 rom_req,
    input  logic                 rom_ack,
    input  logic [INSTR_W-1:0]   rom_data,
    input  logic [PC_W-1:0]      pc_cur,
    output logic                 pc_ld_n,
    output logic [PC_W-1:0]      pc_load,
    input  logic                 carry_in,
    output logic                 exec_valid,
    output logic [OP_W-1:0]      exec_op,
    output logic [IMM_W-1:0]     exec_imm,
    output logic                 carry_flag,
    output logic                 halted
);

    state_t             state;
    state_t             next_state;
    logic [INSTR_W-1:0] instr;
    logic               start;
    logic               br_ld_n;
    logic [PC_W-1:0]    br_load;

`ifdef TD4_SEQ_STEP_EN
    assign start = run | step;
`else
    logic unused_step;
    assign unused_step = step;
    assign start       = run;
`endif

    td4_branch_eval u_branch_eval (
        .op         (instr[INSTR_W-1:IMM_W]),
        .imm        (instr[IMM_W-1:0]),
        .carry_flag (carry_flag),
        .pc_cur     (pc_cur),
        .pc_ld_n    (br_ld_n),
        .pc_load    (br_load)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH:  if (rom_ack) next_state = ST_DECODE;
            ST_DECODE: next_state = ST_EXEC;
            ST_EXEC:   next_state = run ? ST_FETCH : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            instr      <= '0;
            carry_flag <= 1'b0;
        end else begin
            state <= next_state;
            if (state == ST_FETCH && rom_ack) begin
                instr <= rom_data;
            end
            if (state == ST_EXEC) begin
                carry_flag <= is_add_imm(instr[INSTR_W-1:IMM_W]) ? carry_in : 1'b0;
            end
        end
    end

    assign rom_req    = (state == ST_FETCH);
    assign exec_valid = (state == ST_EXEC);
    assign halted     = (state == ST_IDLE);
    assign exec_op    = instr[INSTR_W-1:IMM_W];
    assign exec_imm   = instr[IMM_W-1:0];

    // The counter increments by default, so outside EXEC the PC is held by reloading its own value.
    assign pc_ld_n = (state == ST_EXEC) ? br_ld_n : 1'b0;
    assign pc_load = !reset ? '0 : ((state == ST_EXEC) ? br_load : pc_cur);

endmodule

// File: tb/tb_td4_sequencer.sv
// Self-checking bench for td4_sequencer: directed scenarios plus randomized programs against an instruction-level model.
module tb_td4_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       rom_req;
    logic       rom_ack = 1'b0;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] pc_cur;
    logic       pc_ld_n;
    logic [3:0] pc_load;
    logic       carry_in = 1'b0;
    logic       exec_valid;
    logic [3:0] exec_op;
    logic [3:0] exec_imm;
    logic       carry_flag;
    logic       halted;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] rom [16];
    logic [3:0] model_pc = 4'd0;
    logic       model_carry = 1'b0;
    logic [3:0] last_op = 4'd0;
    logic [3:0] last_imm = 4'd0;

    td4_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .step       (step),
        .rom_req    (rom_req),
        .rom_ack    (rom_ack),
        .rom_data   (rom_data),
        .pc_cur     (pc_cur),
        .pc_ld_n    (pc_ld_n),
        .pc_load    (pc_load),
        .carry_in   (carry_in),
        .exec_valid (exec_valid),
        .exec_op    (exec_op),
        .exec_imm   (exec_imm),
        .carry_flag (carry_flag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Program counter as the external counter instance behaves: load when ld=0, else increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_cur <= 4'd0;
        else if (!pc_ld_n) pc_cur <= pc_load;
        else pc_cur <= pc_cur + 4'd1;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Runs one instruction starting at a negedge inside FETCH, ending at the negedge after EXEC.
    task automatic applyStimulus(input int ack_delay, input logic cin, input logic drop_run);
        logic [7:0] ins;
        logic [3:0] op;
        logic [3:0] imm;
        logic       taken;
        ins   = rom[model_pc];
        op    = ins[7:4];
        imm   = ins[3:0];
        for (int i = 0; i <= ack_delay; i++) begin
            checkOutput("fetch_req", {7'd0, rom_req}, 8'd1);
            checkOutput("fetch_valid", {7'd0, exec_valid}, 8'd0);
            checkOutput("fetch_pc_hold", {4'd0, pc_cur}, {4'd0, model_pc});
            if (i == ack_delay) begin
                rom_ack  = 1'b1;
                rom_data = ins;
            end else begin
                rom_ack  = 1'b0;
                rom_data = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
        checkOutput("decode_req", {7'd0, rom_req}, 8'd0);
        checkOutput("decode_valid", {7'd0, exec_valid}, 8'd0);
        checkOutput("decode_op", {4'd0, exec_op}, {4'd0, op});
        checkOutput("decode_imm", {4'd0, exec_imm}, {4'd0, imm});
        checkOutput("decode_pc_hold", {4'd0, pc_cur}, {4'd0, model_pc});
        @(posedge clk);
        @(negedge clk);
        taken = (op == 4'hF) || (op == 4'hE && model_carry == 1'b0);
        checkOutput("exec_valid", {7'd0, exec_valid}, 8'd1);
        checkOutput("exec_op", {4'd0, exec_op}, {4'd0, op});
        checkOutput("exec_imm", {4'd0, exec_imm}, {4'd0, imm});
        checkOutput("exec_pc_hold", {4'd0, pc_cur}, {4'd0, model_pc});
        checkOutput("exec_ld_n", {7'd0, pc_ld_n}, {7'd0, !taken});
        if (taken) checkOutput("exec_load", {4'd0, pc_load}, {4'd0, imm});
        carry_in = cin;
        if (drop_run) run = 1'b0;
        @(posedge clk);
        model_pc    = taken ? imm : model_pc + 4'd1;
        model_carry = (op == 4'h0 || op == 4'h5) ? cin : 1'b0;
        last_op     = op;
        last_imm    = imm;
        @(negedge clk);
        carry_in = 1'b0;
        checkOutput("next_pc", {4'd0, pc_cur}, {4'd0, model_pc});
        checkOutput("carry", {7'd0, carry_flag}, {7'd0, model_carry});
        checkOutput("post_valid", {7'd0, exec_valid}, 8'd0);
        checkOutput("post_halted", {7'd0, halted}, {7'd0, !run});
    endtask

    // Stay in IDLE with a spurious ack on the bus; nothing may move.
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            rom_ack  = 1'b1;
            rom_data = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("idle_halted", {7'd0, halted}, 8'd1);
            checkOutput("idle_req", {7'd0, rom_req}, 8'd0);
            checkOutput("idle_valid", {7'd0, exec_valid}, 8'd0);
            checkOutput("idle_op", {4'd0, exec_op}, {4'd0, last_op});
            checkOutput("idle_imm", {4'd0, exec_imm}, {4'd0, last_imm});
            checkOutput("idle_pc", {4'd0, pc_cur}, {4'd0, model_pc});
            checkOutput("idle_carry", {7'd0, carry_flag}, {7'd0, model_carry});
        end
        rom_ack = 1'b0;
    endtask

    task automatic resumeRun(input logic with_step);
        run  = 1'b1;
        step = with_step;
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, {7'd0, rom_req}, 8'd0);
        checkOutput({tag, "_ld_n"}, {7'd0, pc_ld_n}, 8'd0);
        checkOutput({tag, "_load"}, {4'd0, pc_load}, 8'd0);
        checkOutput({tag, "_valid"}, {7'd0, exec_valid}, 8'd0);
        checkOutput({tag, "_op"}, {4'd0, exec_op}, 8'd0);
        checkOutput({tag, "_imm"}, {4'd0, exec_imm}, 8'd0);
        checkOutput({tag, "_carry"}, {7'd0, carry_flag}, 8'd0);
        checkOutput({tag, "_halted"}, {7'd0, halted}, 8'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h01;
        @(negedge clk);
        @(negedge clk);
        checkResetValues("reset");
        reset = 1'b1;
        run   = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Back-to-back ADDs with immediate ack, long enough to wrap the PC.
        for (int i = 0; i < 17; i++) applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 1'b0);

        for (int i = 0; i < 16 && model_pc != 4'd3; i++) applyStimulus(0, 1'b0, 1'b0);
        rom[3] = 8'hFA;
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("jmp_target", {4'd0, pc_cur}, 8'd10);
        checkOutput("jmp_carry", {7'd0, carry_flag}, 8'd0);

        rom[10] = 8'h01;
        rom[11] = 8'hE5;
        rom[12] = 8'h01;
        rom[13] = 8'hE5;
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("jnc_not_taken", {4'd0, pc_cur}, 8'd12);
        applyStimulus(0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("jnc_taken", {4'd0, pc_cur}, 8'd5);

        rom[5] = 8'h01;
        rom[6] = 8'h51;
        applyStimulus(1, 1'b1, 1'b1);
        idleCycles(3);
`ifdef TD4_SEQ_STEP_EN
        step = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("step_pc", {4'd0, pc_cur}, 8'd7);
        idleCycles(2);
`else
        step = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step = 1'b0;
        idleCycles(2);
        checkOutput("step_ignored_pc", {4'd0, pc_cur}, 8'd6);
`endif
        resumeRun(1'b1);

        for (int i = 0; i < 16 && model_pc != 4'd6; i++) applyStimulus(0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkResetValues("abort");
        model_pc    = 4'd0;
        model_carry = 1'b0;
        last_op     = 4'd0;
        last_imm    = 4'd0;
        @(posedge clk);
        @(negedge clk);
        checkResetValues("abort_hold");
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        for (int n = 0; n < 300; n++) begin
            logic drop;
            drop = ($urandom_range(0, 7) == 0);
            applyStimulus(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), drop);
            if (drop) begin
                idleCycles(int'($urandom_range(1, 3)));
                resumeRun(1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
